// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM read path.
// Holds the SDRAM geometry, the read-FIFO depth and the burst requester's FSM state type.
package sdram_pkg;

    localparam int unsigned SDRAM_ADDR_W  = 25;
    localparam int unsigned SDRAM_DATA_W  = 16;
    localparam int unsigned RD_FIFO_DEPTH = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_CHECK,
        ST_REQ,
        ST_DRAIN
    } rd_state_e;

endpackage

// File: rtl/read_credit_counter.sv
// Tracks words requested from SDRAM but not yet written to the read FIFO, and
// decides whether a new burst is guaranteed to fit.
// Ports: clk/rst_n; add_i/add_len_i (burst accepted); sub_i (one FIFO write);
//        occ_i (FIFO occupancy); blen_i (candidate burst); inflight_o; room_ok_c.
module read_credit_counter #(
    parameter int unsigned INFL_W     = 7,
    parameter int unsigned BLEN_W     = 4,
    parameter int unsigned OCC_W      = 7,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              add_i,
    input  logic [BLEN_W-1:0] add_len_i,
    input  logic              sub_i,
    input  logic [OCC_W-1:0]  occ_i,
    input  logic [BLEN_W-1:0] blen_i,
    output logic [INFL_W-1:0] inflight_o,
    output logic              room_ok_c
);

    localparam int unsigned MAX_W = (OCC_W > INFL_W)
                                  ? ((OCC_W > BLEN_W) ? OCC_W : BLEN_W)
                                  : ((INFL_W > BLEN_W) ? INFL_W : BLEN_W);
    // Two guard bits so the three-term sum cannot wrap.
    localparam int unsigned CMP_W = MAX_W + 2;

    logic [INFL_W-1:0] inflight_q;
    logic [INFL_W-1:0] inflight_d;

    // Add on burst acceptance and subtract on a FIFO write can both land in one cycle.
    always_comb begin
        inflight_d = inflight_q;
        if (add_i) begin
            inflight_d = inflight_d + INFL_W'(add_len_i);
        end
        if (sub_i) begin
            inflight_d = inflight_d - INFL_W'(1);
        end
    end

    // Room check: current fill + outstanding credit + new burst must fit.
    assign room_ok_c = (CMP_W'(occ_i) + CMP_W'(inflight_q) + CMP_W'(blen_i))
                       <= CMP_W'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign inflight_o = inflight_q;

endmodule

// File: rtl/sdram_read_burst_ctrl.sv
// Read-side burst requester in front of the SDRAM read FIFO. Splits a linear
// read into bursts, issues each only when the FIFO has room for everything
// already in flight, and forwards returned words into the FIFO.
// Ports: clock/aclr_n; start/base_addr/num_words command; busy/done/protocol_err
//        status; rd_req/rd_addr/rd_len/rd_ack request handshake; rd_data/rd_valid
//        return data; fifo_clr/fifo_data/fifo_wrreq/fifo_usedw/fifo_full FIFO side.
module sdram_read_burst_ctrl
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_W     = SDRAM_ADDR_W,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned FIFO_DEPTH = RD_FIFO_DEPTH,
    parameter int unsigned USEDW_W    = 6
) (
    input  logic                      clock,
    input  logic                      aclr_n,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [LEN_W-1:0]          num_words,
    output logic                      busy,
    output logic                      done,
    output logic                      protocol_err,
    output logic                      rd_req,
    output logic [ADDR_W-1:0]         rd_addr,
    output logic [$clog2(BURST_LEN):0] rd_len,
    input  logic                      rd_ack,
    input  logic [SDRAM_DATA_W-1:0]   rd_data,
    input  logic                      rd_valid,
    output logic                      fifo_clr,
    output logic [SDRAM_DATA_W-1:0]   fifo_data,
    output logic                      fifo_wrreq,
    input  logic [USEDW_W-1:0]        fifo_usedw,
    input  logic                      fifo_full
);

    localparam int unsigned BLEN_W = $clog2(BURST_LEN) + 1;
    localparam int unsigned OCC_W  = USEDW_W + 1;
    localparam int unsigned INFL_W = (LEN_W < USEDW_W + 1) ? LEN_W : USEDW_W + 1;

    rd_state_e                state_q,      state_d;
    logic [ADDR_W-1:0]        addr_q,       addr_d;
    logic [LEN_W-1:0]         remaining_q,  remaining_d;
    logic                     rd_req_q,     rd_req_d;
    logic [ADDR_W-1:0]        rd_addr_q,    rd_addr_d;
    logic [BLEN_W-1:0]        rd_len_q,     rd_len_d;
    logic                     busy_q,       busy_d;
    logic                     done_q,       done_d;
    logic                     fifo_clr_q,   fifo_clr_d;
    logic [SDRAM_DATA_W-1:0]  fifo_data_q,  fifo_data_d;
    logic                     fifo_wrreq_q, fifo_wrreq_d;
    logic                     perr_q,       perr_d;

    logic [BLEN_W-1:0]        blen_c;
    logic [OCC_W-1:0]         occ_c;
    logic [INFL_W-1:0]        inflight;
    logic                     room_ok_c;
    logic                     credit_add_c;
    logic                     nothing_owed_c;

    assign blen_c = (remaining_q >= LEN_W'(BURST_LEN)) ? BLEN_W'(BURST_LEN)
                                                       : BLEN_W'(remaining_q);
    assign occ_c  = fifo_full ? OCC_W'(FIFO_DEPTH) : OCC_W'(fifo_usedw);

    // Every counted word except one already sitting in the write register has yet to return.
    assign nothing_owed_c = (inflight == INFL_W'(fifo_wrreq_q));

    read_credit_counter #(
        .INFL_W     (INFL_W),
        .BLEN_W     (BLEN_W),
        .OCC_W      (OCC_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_credit (
        .clk        (clock),
        .rst_n      (aclr_n),
        .add_i      (credit_add_c),
        .add_len_i  (rd_len_q),
        .sub_i      (fifo_wrreq_q),
        .occ_i      (occ_c),
        .blen_i     (blen_c),
        .inflight_o (inflight),
        .room_ok_c  (room_ok_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        rd_req_d     = rd_req_q;
        rd_addr_d    = rd_addr_q;
        rd_len_d     = rd_len_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fifo_clr_d   = 1'b0;
        perr_d       = perr_q;
        credit_add_c = 1'b0;

        // Return data is forwarded in every state; unsolicited words are dropped.
        fifo_wrreq_d = rd_valid && !nothing_owed_c;
        fifo_data_d  = fifo_wrreq_d ? rd_data : fifo_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = num_words;
                    perr_d      = 1'b0;
                    busy_d      = 1'b1;
                    fifo_clr_d  = 1'b1;
                    state_d     = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = (remaining_q == '0) ? ST_DRAIN : ST_CHECK;
            end
            ST_CHECK: begin
                if (room_ok_c) begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = addr_q;
                    rd_len_d  = blen_c;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (rd_ack) begin
                    credit_add_c = 1'b1;
                    addr_d       = addr_q + ADDR_W'(rd_len_q);
                    remaining_d  = remaining_q - LEN_W'(rd_len_q);
                    rd_req_d     = 1'b0;
                    state_d      = (remaining_d != '0) ? ST_CHECK : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rd_valid && nothing_owed_c) begin
            perr_d = 1'b1;
        end

        // Finish as soon as the final write is leaving, so done follows it by one cycle.
        if (state_d == ST_DRAIN && !credit_add_c && nothing_owed_c) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            rd_len_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fifo_clr_q   <= 1'b0;
            fifo_data_q  <= '0;
            fifo_wrreq_q <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            rd_len_q     <= rd_len_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fifo_clr_q   <= fifo_clr_d;
            fifo_data_q  <= fifo_data_d;
            fifo_wrreq_q <= fifo_wrreq_d;
            perr_q       <= perr_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign protocol_err = perr_q;
    assign rd_req       = rd_req_q;
    assign rd_addr      = rd_addr_q;
    assign rd_len       = rd_len_q;
    assign fifo_clr     = fifo_clr_q;
    assign fifo_data    = fifo_data_q;
    assign fifo_wrreq   = fifo_wrreq_q;

endmodule

// File: tb/tb_sdram_read_burst_ctrl.sv
// Scoreboard bench for sdram_read_burst_ctrl: directed transfers push expected
// requests, FIFO writes and done pulses; a monitor pops and compares them.
module tb_sdram_read_burst_ctrl;

    logic        clock;
    logic        aclr_n;
    logic        start;
    logic [24:0] base_addr;
    logic [15:0] num_words;
    logic        busy;
    logic        done;
    logic        protocol_err;
    logic        rd_req;
    logic [24:0] rd_addr;
    logic [3:0]  rd_len;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        fifo_clr;
    logic [15:0] fifo_data;
    logic        fifo_wrreq;
    logic [5:0]  fifo_usedw;
    logic        fifo_full;

    sdram_read_burst_ctrl dut (
        .clock        (clock),
        .aclr_n       (aclr_n),
        .start        (start),
        .base_addr    (base_addr),
        .num_words    (num_words),
        .busy         (busy),
        .done         (done),
        .protocol_err (protocol_err),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_len       (rd_len),
        .rd_ack       (rd_ack),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .fifo_clr     (fifo_clr),
        .fifo_data    (fifo_data),
        .fifo_wrreq   (fifo_wrreq),
        .fifo_usedw   (fifo_usedw),
        .fifo_full    (fifo_full)
    );

    int n_chk;
    int n_fail;

    logic [28:0] exp_req[$];
    logic [15:0] exp_wr[$];
    int          exp_done;
    int          req_seen;
    int          wr_seen;
    int          done_seen;

    logic [24:0] ret_q[$];
    int          ret_t[$];
    int          cyc;
    logic        ack_en;
    logic        spur;

    int          cnt;
    int          max_cnt;
    int          clr_fill;
    int          pop_budget;
    logic        cons_en;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [15:0] data_of(input logic [24:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_burst(input logic [24:0] a, input int len);
        exp_req.push_back({a, 4'(len)});
        for (int i = 0; i < len; i++) begin
            exp_wr.push_back(data_of(a + 25'(i)));
        end
    endtask

    task automatic do_start(input logic [24:0] a, input logic [15:0] n);
        @(posedge clock);
        #1;
        start     = 1'b1;
        base_addr = a;
        num_words = n;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (k < budget && !(exp_req.size() == 0 && exp_wr.size() == 0 &&
                               exp_done == 0 && !busy)) begin
            @(negedge clock);
            k++;
        end
        n_chk++;
        if (k >= budget) begin
            n_fail++;
            $display("FAIL %s_timeout: actual busy=%0d reqs_left=%0d writes_left=%0d required idle",
                     name, busy, exp_req.size(), exp_wr.size());
        end
    endtask

    // SDRAM responder: instant ack, words returned 4 cycles after the ack.
    initial begin
        rd_ack   = 1'b0;
        rd_valid = 1'b0;
        rd_data  = '0;
        cyc      = 0;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            rd_ack = rd_req && ack_en;
            if (rd_req && ack_en) begin
                for (int i = 0; i < int'(rd_len); i++) begin
                    ret_q.push_back(rd_addr + 25'(i));
                    ret_t.push_back(cyc + 4);
                end
            end
            if (spur) begin
                rd_valid = 1'b1;
                rd_data  = 16'hDEAD;
                spur     = 1'b0;
            end else if (ret_q.size() > 0 && ret_t[0] <= cyc) begin
                rd_valid = 1'b1;
                rd_data  = data_of(ret_q.pop_front());
                void'(ret_t.pop_front());
            end else begin
                rd_valid = 1'b0;
            end
        end
    end

    // Downstream FIFO occupancy model with a throttleable consumer.
    initial begin
        logic w;
        logic c;
        logic p;
        cnt        = 0;
        max_cnt    = 0;
        fifo_usedw = '0;
        fifo_full  = 1'b0;
        forever begin
            @(negedge clock);
            w = fifo_wrreq;
            c = fifo_clr;
            p = (cnt > 0) && (cons_en || pop_budget > 0);
            if (p && !cons_en) pop_budget--;
            @(posedge clock);
            #1;
            if (c) cnt = clr_fill;
            else   cnt = cnt + (w ? 1 : 0) - (p ? 1 : 0);
            if (cnt > max_cnt) max_cnt = cnt;
            fifo_usedw = 6'(cnt);
            fifo_full  = (cnt >= 64);
        end
    end

    // Monitor: compares every request handshake, FIFO write and done pulse.
    initial begin
        logic [28:0] e;
        forever begin
            @(negedge clock);
            if (aclr_n) begin
                if (rd_req && rd_ack) begin
                    req_seen++;
                    if (exp_req.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL req_unexpected: actual addr %0h len %0d required no request",
                                 rd_addr, rd_len);
                    end else begin
                        e = exp_req.pop_front();
                        check("req_addr_len", 64'({rd_addr, rd_len}), 64'(e));
                    end
                end
                if (fifo_wrreq) begin
                    wr_seen++;
                    if (exp_wr.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL write_unexpected: actual data %0h required no write", fifo_data);
                    end else begin
                        check("fifo_write_data", 64'(fifo_data), 64'(exp_wr.pop_front()));
                    end
                end
                if (done) begin
                    done_seen++;
                    n_chk++;
                    if (exp_done == 0) begin
                        n_fail++;
                        $display("FAIL done_unexpected: actual done=1 required done=0");
                    end else begin
                        exp_done--;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        int base_r;
        int base_w;
        int base_d;
        int k;
        n_chk = 0; n_fail = 0;
        exp_done = 0; req_seen = 0; wr_seen = 0; done_seen = 0;
        aclr_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
        ack_en = 1'b1; spur = 1'b0;
        cons_en = 1'b1; pop_budget = 0; clr_fill = 0;

        repeat (3) @(negedge clock);
        check("reset_outputs", 64'({busy, done, rd_req, fifo_clr, fifo_wrreq, protocol_err,
                                    rd_addr, rd_len, fifo_data}), 64'd0);
        aclr_n = 1'b1;

        // 20 words from 0x100: bursts of 8, 8, 4.
        push_burst(25'h100, 8);
        push_burst(25'h108, 8);
        push_burst(25'h110, 4);
        exp_done++;
        base_w = wr_seen; base_d = done_seen;
        do_start(25'h100, 16'd20);
        @(negedge clock);
        check("flush_cycle", 64'({busy, fifo_clr, rd_req}), 64'(3'b110));
        @(negedge clock);
        check("check_cycle", 64'({busy, fifo_clr, rd_req}), 64'(3'b100));
        @(negedge clock);
        check("first_req", 64'({rd_req, rd_addr, rd_len}), 64'({1'b1, 25'h100, 4'd8}));
        wait_idle("main", 300);
        check("main_writes", 64'(wr_seen - base_w), 64'd20);
        check("main_done", 64'(done_seen - base_d), 64'd1);

        // FIFO held at 60 with consumer stalled: no room for 8 until it drains to 56.
        cons_en = 1'b0; pop_budget = 0; clr_fill = 60;
        base_r = req_seen;
        exp_done++;
        do_start(25'h400, 16'd8);
        repeat (20) @(negedge clock);
        check("stall_no_req", 64'(req_seen - base_r), 64'd0);
        check("stall_rd_req", 64'(rd_req), 64'd0);
        push_burst(25'h400, 8);
        pop_budget = 4;
        wait_idle("stall", 300);
        check("stall_one_req", 64'(req_seen - base_r), 64'd1);
        check("no_overflow", 64'(max_cnt > 64), 64'd0);
        clr_fill = 0; cons_en = 1'b1;

        // Address wrap at the top of the SDRAM space.
        push_burst(25'h1FFFFFC, 8);
        exp_done++;
        do_start(25'h1FFFFFC, 16'd8);
        wait_idle("wrap", 300);
        check("wrap_addr", 64'(dut.addr_q), 64'h4);

        // Zero-length transfer, then an unsolicited return word.
        base_r = req_seen; base_w = wr_seen;
        exp_done++;
        do_start(25'h50, 16'd0);
        @(negedge clock);
        check("zero_flush", 64'({busy, fifo_clr, done}), 64'(3'b110));
        @(negedge clock);
        check("zero_done", 64'({busy, done, rd_req}), 64'(3'b010));
        spur = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check("spurious_perr", 64'({protocol_err, fifo_wrreq}), 64'(2'b10));
        check("zero_no_req", 64'(req_seen - base_r), 64'd0);
        check("spurious_no_write", 64'(wr_seen - base_w), 64'd0);

        // Reset in the middle of the second burst.
        push_burst(25'h200, 8);
        push_burst(25'h208, 8);
        push_burst(25'h210, 4);
        exp_done++;
        base_w = wr_seen;
        do_start(25'h200, 16'd20);
        @(negedge clock);
        check("start_clears_perr", 64'(protocol_err), 64'd0);
        k = 0;
        while (k < 300 && wr_seen - base_w < 10) begin
            @(negedge clock);
            k++;
        end
        check("reach_second_burst", 64'(k < 300), 64'd1);
        base_d = done_seen;
        aclr_n = 1'b0;
        #1;
        check("abort_outputs", 64'({busy, done, rd_req, fifo_clr, fifo_wrreq, protocol_err,
                                    rd_addr, rd_len, fifo_data}), 64'd0);
        repeat (2) @(negedge clock);
        exp_req.delete();
        exp_wr.delete();
        ret_q.delete();
        ret_t.delete();
        exp_done = 0;
        @(negedge clock);
        aclr_n = 1'b1;
        @(negedge clock);
        check("abort_no_done", 64'(done_seen - base_d), 64'd0);

        // Fresh transfer completes; a start while busy is ignored.
        push_burst(25'h300, 8);
        push_burst(25'h308, 8);
        push_burst(25'h310, 4);
        exp_done++;
        base_w = wr_seen; base_d = done_seen;
        do_start(25'h300, 16'd20);
        repeat (3) @(negedge clock);
        check("busy_during_xfer", 64'(busy), 64'd1);
        do_start(25'h777, 16'd5);
        wait_idle("restart", 300);
        check("restart_writes", 64'(wr_seen - base_w), 64'd20);
        check("restart_done", 64'(done_seen - base_d), 64'd1);
        check("final_no_overflow", 64'(max_cnt > 64), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_read_burst_ctrl.md
# sdram_read_burst_ctrl

Read-side burst requester sitting directly upstream of the 64×16 SDRAM read FIFO. On a start command it splits a linear word-addressed read into SDRAM burst requests, issues each burst only when the FIFO is guaranteed room for every word already requested plus the new burst, and writes returned words into the FIFO. The FIFO has overflow checking off, so this block's credit accounting is the only overflow protection on the read path.

## Interface
- `ADDR_W`, default 25: SDRAM word-address width.
- `LEN_W`, default 16: transfer length width, in words.
- `BURST_LEN`, default 8: maximum words per SDRAM request; power of two, ≤ `FIFO_DEPTH`.
- `FIFO_DEPTH`, default 64: downstream FIFO capacity in words.
- `USEDW_W`, default 6: FIFO `usedw` width, equal to log2(`FIFO_DEPTH`).

Ports:
- `clock` in 1: single clock domain.
- `aclr_n` in 1: asynchronous reset, active-low.
- `start` in 1: one-cycle command pulse; ignored unless `busy`=0.
- `base_addr` in `ADDR_W`: first word address, sampled on `start`.
- `num_words` in `LEN_W`: transfer length in words, sampled on `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when all words have been written to the FIFO.
- `protocol_err` out 1: sticky flag; set when `rd_valid` arrives with zero words outstanding; cleared on `start`.
- `rd_req` out 1: burst request; held until `rd_ack`.
- `rd_addr` out `ADDR_W`: burst start address, stable while `rd_req`=1.
- `rd_len` out log2(`BURST_LEN`)+1: words in this burst, 1..`BURST_LEN`.
- `rd_ack` in 1: controller accepts the request in this cycle.
- `rd_data` in 16: returned SDRAM word.
- `rd_valid` in 1: `rd_data` is valid this cycle.
- `fifo_clr` out 1: one-cycle FIFO clear pulse, active-high.
- `fifo_data` out 16: FIFO write data.
- `fifo_wrreq` out 1: FIFO write strobe.
- `fifo_usedw` in `USEDW_W`: FIFO fill level.
- `fifo_full` in 1: FIFO full flag.

## Operation
- FSM states: IDLE, FLUSH, CHECK, REQ, DRAIN.
- IDLE, on `start`:
  - latch `base_addr` → `addr` and `num_words` → `remaining`;
  - clear `protocol_err`;
  - go to FLUSH.
- FLUSH (one cycle):
  - `fifo_clr`=1.
  - If `remaining`=0, go to DRAIN; otherwise go to CHECK.
- CHECK:
  - Set `blen` = min(`remaining`, `BURST_LEN`).
  - Set `occ` = `fifo_full` ? `FIFO_DEPTH` : `fifo_usedw`.
  - If `occ` + `inflight` + `blen` ≤ `FIFO_DEPTH`, drive `rd_addr`=`addr` and `rd_len`=`blen`, then go to REQ. Otherwise stay in CHECK.
- REQ:
  - Hold `rd_req`=1 with `rd_addr` and `rd_len` stable.
  - On `rd_ack`: `inflight` += `blen`, `addr` += `blen` (modulo 2^`ADDR_W`, wrapping silently), `remaining` −= `blen`.
  - Next state: CHECK if `remaining` is still nonzero, otherwise DRAIN.
- DRAIN: when `inflight`=0 and no write is pending, pulse `done` and go to IDLE.
- Data path:
  - `rd_valid` registers `rd_data` into `fifo_data` and sets `fifo_wrreq` on the next cycle.
  - `inflight` decrements by 1 in each cycle that `fifo_wrreq`=1.
  - `inflight` is (LEN_W min `USEDW_W`+1) wide. Add and subtract in the same cycle both apply.
- Return data is accepted in every state, including IDLE.
- A `start` while `busy`=1 is ignored.
- `rd_valid` with `inflight`=0 and no pending write: set `protocol_err`, write nothing.

## Timing
- Reset values: `busy`, `done`, `rd_req`, `fifo_clr`, `fifo_wrreq`, `protocol_err` = 0; `rd_addr`, `rd_len`, `fifo_data` = 0; state IDLE; counters 0.
- Reset mid-transfer aborts immediately. No `done` is produced. The FIFO is not cleared by this block's reset.
- `start` at edge N → `busy`=1 and `fifo_clr`=1 at N+1 → first `rd_req` no earlier than N+3.
- `rd_valid` at edge N → `fifo_wrreq` at N+1. Fixed one-cycle latency, no backpressure.
- Minimum one CHECK cycle between successive requests.
- `done` asserts the cycle after the last `fifo_wrreq`. `busy` drops in the same cycle as `done`.

## Structure
- Shared package `sdram_pkg`:
  - FSM state enum;
  - `SDRAM_ADDR_W`=25, `SDRAM_DATA_W`=16;
  - read-FIFO depth constant 64.
- One sub-module, `read_credit_counter`: owns `inflight` and the room-check comparison.
- Top level holds the FSM, address/length registers and data register.

## Test plan
- `base_addr`=0x100, `num_words`=20, instant `rd_ack`, data returned 4 cycles after each ack → bursts (0x100,8), (0x108,8), (0x110,4); 20 FIFO writes in order; one `done`.
- FIFO model held at `usedw`=60 with consumer stalled, `num_words`=8 → no `rd_req` issued; drain to 56 → request issued the next CHECK cycle; `fifo_full` never overflows.
- `base_addr`=2^25−4, `num_words`=8, `BURST_LEN`=8 → single burst at 0x1FFFFFC; internal `addr` wraps to 0x0000004.
- `num_words`=0 → `fifo_clr` pulse, no `rd_req`, `done` 2 cycles after `start`. Spurious `rd_valid` in IDLE → `protocol_err`=1, no FIFO write.
- `aclr_n` low in the middle of the second burst → all outputs return to reset values; a new `start` afterwards completes normally with correct count. A `start` while `busy` is ignored.
